// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch stage: PC, imem req/ack fetch, retire-time redirect and trap
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] target,
  output logic        misaligned,
  output logic [31:0] retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        fetch_done;
  logic        retire;
  logic        take;
  logic        trap;
  logic [31:0] next_pc;

  // Retire-time control decode: pick the successor PC and spot a misaligned taken target.
  always_comb begin
    fetch_done = (state == S_FETCH) && imem_ack;
    retire     = (state == S_HOLD) && instr_ready;
    take       = (branch && zero) || jump;
    next_pc    = take ? target : pc_plus4;
    trap       = retire && take && (target[1:0] != 2'b00);
  end

  // Next-state logic; S_HALT is only left through reset.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (imem_ack) state_next = S_HOLD;
      S_HOLD:  if (instr_ready) state_next = trap ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Program counter: advances only on a non-trapping retire, so a trap leaves the faulting pc visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pc <= RESET_PC;
    else if (retire && !trap)  pc <= next_pc;
  end

  // Instruction register: captured on the ack that ends a fetch, returned to NOP on retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr <= NOP_INSTR;
    else if (fetch_done) instr <= imem_rdata;
    else if (retire)     instr <= NOP_INSTR;
  end

  // Retired-instruction counter, wrapping naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= 32'd0;
    else if (retire) retired <= retired + 32'd1;
  end

  // Sticky misaligned-target flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    misaligned <= 1'b0;
    else if (trap) misaligned <= 1'b1;
  end

  // Handshake outputs decode the registered state only, so inputs never reach them combinationally.
  always_comb begin
    imem_req    = (state == S_FETCH);
    instr_valid = (state == S_HOLD);
    imem_addr   = pc;
    pc_plus4    = pc + 32'd4;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] target = 32'd0;
  logic        misaligned;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic [31:0] exp_fetch[$];
  logic [31:0] exp_instr[$];
  logic [31:0] cur_pc = 32'd0;
  logic [31:0] ret_seen = 32'd0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4),
    .branch(branch), .jump(jump), .zero(zero), .target(target),
    .misaligned(misaligned), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected fetch address on each accepted ack and the expected instruction on each retire.
  always @(negedge clk) begin
    if (!rst_n) begin
      ret_seen = 32'd0;
    end else if (mon_en) begin
      if (imem_req && imem_ack) begin
        if (exp_fetch.size() == 0) check32("sb_fetch_underflow", 32'd1, 32'd0);
        else begin
          cur_pc = exp_fetch.pop_front();
          check32("sb_imem_addr", imem_addr, cur_pc);
        end
      end
      if (instr_valid && instr_ready) begin
        if (exp_instr.size() == 0) check32("sb_instr_underflow", 32'd1, 32'd0);
        else check32("sb_instr", instr, exp_instr.pop_front());
        check32("sb_pc", pc, cur_pc);
        check32("sb_pc_plus4", pc_plus4, cur_pc + 32'd4);
        check32("sb_retired", retired, ret_seen);
        check32("sb_misaligned_clear", {31'd0, misaligned}, 32'd0);
        ret_seen = ret_seen + 32'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    tick(); tick();
    exp_fetch.delete(); exp_instr.delete();
    exp_fetch.push_back(RESET_PC);
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin tick(); n++; end
    if (!imem_req) check32("wait_req_timeout", 32'd0, 32'd1);
  endtask

  // One full fetch (zero-wait ack) followed by a retire with the given control bits.
  task automatic fetch_retire(input logic [31:0] data, input logic b, input logic j,
                              input logic z, input logic [31:0] tgt);
    wait_req();
    imem_ack = 1'b1; imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    check32("fr_valid", {31'd0, instr_valid}, 32'd1);
    check32("fr_instr", instr, data);
    instr_ready = 1'b1; branch = b; jump = j; zero = z; target = tgt;
    tick();
    instr_ready = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
  endtask

  logic [31:0] m_pc;
  logic [31:0] nxt;
  logic        take;
  logic        halted;
  int          halt_cnt;
  int          lat;

  initial begin
    // Reset values while rst_n is held low.
    tick(); tick();
    check32("rst_pc", pc, RESET_PC);
    check32("rst_instr", instr, NOP_INSTR);
    check32("rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check32("rst_retired", retired, 32'd0);
    check32("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);

    // Zero-wait memory, instr_ready held high: fetch addresses 0,4,8 every other cycle.
    rst_n = 1'b1;
    check32("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h0000_0013;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        check32("zw_req", {31'd0, imem_req}, 32'd1);
        check32("zw_addr", imem_addr, 32'(k * 2));
      end
      tick();
    end
    check32("zw_retired", retired, 32'd3);

    // Ack delayed by 3 cycles: request held 4 cycles with a stable address.
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      check32("dl_req", {31'd0, imem_req}, 32'd1);
      check32("dl_addr", imem_addr, 32'h0);
      check32("dl_valid_low", {31'd0, instr_valid}, 32'd0);
      if (k == 3) begin imem_ack = 1'b1; imem_rdata = 32'h0050_0093; end
      tick();
    end
    imem_ack = 1'b0;
    check32("dl_valid", {31'd0, instr_valid}, 32'd1);
    check32("dl_instr", instr, 32'h0050_0093);
    instr_ready = 1'b1; jump = 1'b1; target = 32'h10;
    tick();
    instr_ready = 1'b0; jump = 1'b0;
    check32("jmp_addr", imem_addr, 32'h10);
    check32("jmp_instr_nop", instr, NOP_INSTR);
    check32("jmp_retired", retired, 32'd1);

    // Branch taken and not taken from pc 0x10; not-taken misaligned target does not trap.
    fetch_retire(32'h1111_0063, 1'b1, 1'b0, 1'b1, 32'h40);
    check32("br_taken", imem_addr, 32'h40);
    fetch_retire(32'h2222_006f, 1'b0, 1'b1, 1'b0, 32'h10);
    fetch_retire(32'h3333_0063, 1'b1, 1'b0, 1'b0, 32'h40);
    check32("br_not_taken", imem_addr, 32'h14);
    fetch_retire(32'h4444_0063, 1'b1, 1'b0, 1'b0, 32'h103);
    check32("nt_misal_addr", imem_addr, 32'h18);
    check32("nt_misal_flag", {31'd0, misaligned}, 32'd0);

    // Misaligned jump target traps and halts until reset.
    fetch_retire(32'h5555_006f, 1'b0, 1'b1, 1'b0, 32'h20);
    fetch_retire(32'h6666_006f, 1'b0, 1'b1, 1'b0, 32'h102);
    check32("trap_flag", {31'd0, misaligned}, 32'd1);
    check32("trap_retired", retired, 32'd7);
    for (int k = 0; k < 5; k++) begin
      imem_ack = 1'b1; instr_ready = 1'b1;
      check32("trap_pc", pc, 32'h20);
      check32("trap_req", {31'd0, imem_req}, 32'd0);
      check32("trap_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    check32("trap_retired_frozen", retired, 32'd7);
    do_reset();
    check32("trap_rst_pc", pc, RESET_PC);
    check32("trap_rst_flag", {31'd0, misaligned}, 32'd0);

    // PC wrap at the top of the address space.
    fetch_retire(32'h7777_006f, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    wait_req();
    check32("wrap_pc", pc, 32'hFFFF_FFFC);
    check32("wrap_pc_plus4", pc_plus4, 32'h0);
    fetch_retire(32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0);
    check32("wrap_addr", imem_addr, 32'h0);

    // Reset asserted mid-fetch with an ack in the same cycle.
    fetch_retire(32'h8888_006f, 1'b0, 1'b1, 1'b0, 32'h80);
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    #1;
    check32("arst_req", {31'd0, imem_req}, 32'd0);
    check32("arst_valid", {31'd0, instr_valid}, 32'd0);
    check32("arst_pc", pc, RESET_PC);
    tick();
    check32("arst_instr", instr, NOP_INSTR);
    check32("arst_retired", retired, 32'd0);
    imem_ack = 1'b0;

    // Randomized run against the reference model and scoreboard.
    do_reset();
    mon_en = 1'b1;
    m_pc = RESET_PC; halted = 1'b0; halt_cnt = 0; lat = int'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      imem_ack = 1'b0; instr_ready = 1'b0;
      branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom);
      target = $urandom; imem_rdata = $urandom;
      if (halted) begin
        halt_cnt++;
        if (halt_cnt == 3) begin
          check32("rnd_trap_flag", {31'd0, misaligned}, 32'd1);
          check32("rnd_trap_req", {31'd0, imem_req}, 32'd0);
          check32("rnd_trap_pc", pc, m_pc);
        end
        if (halt_cnt == 4) begin
          rst_n = 1'b0;
          exp_fetch.delete(); exp_instr.delete();
          exp_fetch.push_back(RESET_PC);
          m_pc = RESET_PC;
        end
        if (halt_cnt == 6) begin rst_n = 1'b1; halted = 1'b0; end
      end else begin
        if (imem_req) begin
          if (lat == 0) begin
            imem_ack = 1'b1;
            exp_instr.push_back(imem_rdata);
            lat = int'($urandom_range(0, 3));
          end else lat--;
        end else if ($urandom_range(0, 7) == 0) imem_ack = 1'b1;
        if (instr_valid && $urandom_range(0, 3) != 0) begin
          instr_ready = 1'b1;
          jump = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 7))
            0:       target = 32'hFFFF_FFFC;
            1:       target = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            default: target = $urandom & 32'hFFFF_FFFC;
          endcase
          take = (branch && zero) || jump;
          nxt  = take ? target : m_pc + 32'd4;
          if (take && target[1:0] != 2'b00) begin
            halted = 1'b1; halt_cnt = 0;
          end else begin
            m_pc = nxt;
            exp_fetch.push_back(nxt);
          end
        end
      end
    end
    mon_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RISC-V core: holds the program counter, requests instructions from instruction memory over a req/ack handshake, and presents one instruction at a time to the main decoder, whose opcode is taken from instr[6:0]. At instruction retire it consumes the control results of that instruction (branch, jump, ALU zero flag, target address) to select the next PC. It also traps misaligned control-flow targets and counts retired instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, value driven on instr whenever no valid instruction is held (addi x0,x0,0).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  32  fetch address (= pc); stable while imem_req is high.
- imem_ack  input  1  imem_rdata valid this cycle; ignored unless imem_req is high.
- imem_rdata  input  32  instruction word from memory.
- instr  output  32  current instruction to the decoder.
- instr_valid  output  1  instr and pc are valid.
- instr_ready  input  1  downstream retires the instruction this cycle.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32; used for JAL write-back.
- branch, jump, zero  input  1 each  control of the retiring instruction; sampled only at retire.
- target  input  32  branch/jump target; sampled only at retire.
- misaligned  output  1  sticky error: a taken target had target[1:0] != 0.
- retired  output  32  count of retired instructions; wraps modulo 2^32.

## Operation
- States: S_IDLE, S_FETCH, S_HOLD, S_HALT. The reset state is S_IDLE.
- S_IDLE: unconditionally moves to S_FETCH on the next cycle.
- S_FETCH: imem_req=1, imem_addr=pc. On imem_ack, instr is loaded from imem_rdata, instr_valid is set, and the FSM moves to S_HOLD. Without ack it stays, with no timeout.
- S_HOLD: instr_valid=1. instr and pc stay stable until retire. Retire is instr_ready=1 in this state.
- At retire:
  - take = (branch & zero) | jump.
  - next = take ? target : pc + 4 (32-bit wrap).
  - retired increments by 1.
  - instr_valid clears and instr returns to NOP_INSTR.
- At retire, if take=1 and target[1:0] != 0: pc is unchanged, misaligned is set, and the FSM enters S_HALT. Otherwise pc <= next and the FSM enters S_FETCH.
- When take=0, target is ignored; a misaligned target does not trap.
- S_HALT: imem_req=0, instr_valid=0. Only reset exits this state.
- imem_ack outside S_FETCH is ignored, and imem_rdata is not captured.
- instr_ready outside S_HOLD is ignored; retired does not count.
- branch, jump, zero and target are don't-care outside a retire cycle.

## Timing
- Reset values (applied asynchronously while rst_n=0):
  - pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0.
  - misaligned=0, retired=0, state=S_IDLE.
- Reset mid-fetch or mid-hold: imem_req and instr_valid drop immediately; any outstanding ack is discarded.
- imem_req, instr_valid and misaligned are decoded from registered state only; no combinational path from any input.
- pc_plus4 is combinational from pc.
- First request: imem_req rises in the 2nd rising edge's cycle after rst_n deasserts (S_IDLE lasts one cycle).
- Ack latency N ≥ 0 cycles after req: instr_valid rises on the edge following the ack cycle.
- Throughput: with ack in the same cycle as req and instr_ready=1, one instruction retires every 2 cycles.
- The redirect is visible on imem_addr in the cycle after retire.
- The retired increment and misaligned set both take effect on the retire edge.

## Test plan
- Reset then zero-wait memory, instr_ready=1, all control 0: imem_addr sequence 0x0, 0x4, 0x8 every 2 cycles; retired=3 after 6 cycles post-IDLE.
- Ack delayed 3 cycles with rdata=0x00500093: imem_req held for 4 cycles, addr stable; instr=0x00500093, instr_valid=1 on the next edge.
- Retire at pc=0x10 with branch=1, zero=1, target=0x40: next imem_addr=0x40. Same with zero=0: next imem_addr=0x14.
- jump=1, target=0x102 at pc=0x20: misaligned=1, pc stays 0x20, imem_req=0 permanently. Then rst_n pulse: pc=RESET_PC, misaligned=0.
- pc=0xFFFF_FFFC, no branch: pc_plus4=0x0; after retire imem_addr=0x0. retired preset near 0xFFFF_FFFF wraps to 0.
- rst_n asserted while imem_req=1, with ack arriving in the same cycle: outputs show reset values immediately; no instr capture.
